// File: rtl/seq_restoring_divider_if.sv
// Handshake and operand/result bundle for the sequential restoring divider.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             ld;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output ld, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  ld, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, WIDTH iterations per operation.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  seq_restoring_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t state, state_nxt;

  // The restored partial remainder is always below M, so its sign bit is
  // always zero; only the trial difference T carries the WIDTH+1 sign bit.
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   diff;
  logic             neg;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             last_iter;

  always_comb begin
    a_shift   = {a, q[WIDTH-1]};
    diff      = a_shift - {1'b0, m};
    neg       = diff[WIDTH];
    a_nxt     = neg ? a_shift[WIDTH-1:0] : diff[WIDTH-1:0];
    q_nxt     = {q[WIDTH-2:0], ~neg};
    last_iter = (cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    unique case (state)
      IDLE: state_nxt = bus.ld ? CALC : IDLE;
      CALC: begin
        bus.busy  = 1'b1;
        state_nxt = last_iter ? DONE : CALC;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a               <= '0;
      q               <= '0;
      m               <= '0;
      cnt             <= '0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ld) begin
            a   <= '0;
            q   <= bus.dividend;
            m   <= bus.divisor;
            cnt <= CW'(WIDTH);
          end
        end
        CALC: begin
          a   <= a_nxt;
          q   <= q_nxt;
          cnt <= cnt - CW'(1);
          if (last_iter) begin
            bus.quotient    <= q_nxt;
            bus.remainder   <= a_nxt;
            bus.div_by_zero <= (m == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
